// File: rtl/tty_tx_sequencer_if.sv
// Handshake bundle between the IOT decode / divider side and the teleprinter
// frame sequencer. The sequencer connects through the slave modport.
interface tty_tx_sequencer_if #(
  parameter int DATA_BITS = 8
) ();

  logic                 tick16;
  logic                 div_clr;
  logic                 ld;
  logic [DATA_BITS-1:0] data;
  logic                 clr_flag;
  logic                 txd;
  logic                 busy;
  logic                 flag;
  logic                 overrun;

  modport master (
    output tick16,
    output ld,
    output data,
    output clr_flag,
    input  div_clr,
    input  txd,
    input  busy,
    input  flag,
    input  overrun
  );

  modport slave (
    input  tick16,
    input  ld,
    input  data,
    input  clr_flag,
    output div_clr,
    output txd,
    output busy,
    output flag,
    output overrun
  );

endinterface

// File: rtl/tty_tx_sequencer.sv
// Teleprinter transmit frame sequencer: start bit, LSB-first data, stop bits,
// timed by the shared 16x tick stream, with a sticky PDP-8 style printer flag.
module tty_tx_sequencer #(
  parameter int DATA_BITS     = 8,
  parameter int STOP_BITS     = 2,
  parameter int TICKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  tty_tx_sequencer_if.slave     bus
);

  localparam int              TW        = $clog2(TICKS_PER_BIT) + 1;
  localparam logic [TW-1:0]   TICK_LAST = TW'(TICKS_PER_BIT - 1);
  localparam logic [3:0]      DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]      STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [TW-1:0]          tick_cnt_r;
  logic [TW-1:0]          tick_cnt_s;
  logic [3:0]             bit_cnt_r;
  logic [3:0]             bit_cnt_s;
  logic [DATA_BITS-1:0]   shreg_r;
  logic [DATA_BITS-1:0]   shreg_s;
  logic                   txd_r;
  logic                   txd_s;
  logic                   busy_r;
  logic                   busy_s;
  logic                   flag_r;
  logic                   flag_s;
  logic                   overrun_r;
  logic                   overrun_s;
  logic                   div_clr_r;
  logic                   div_clr_s;
  logic                   tick_en_s;
  logic                   cell_end_s;
  logic                   done_s;
  logic                   accept_s;

  // Next-state, counter, shift register and output decode.
  always_comb begin
    state_s    = state_r;
    tick_cnt_s = tick_cnt_r;
    bit_cnt_s  = bit_cnt_r;
    shreg_s    = shreg_r;
    flag_s     = flag_r;
    overrun_s  = overrun_r;
    div_clr_s  = 1'b0;
    done_s     = 1'b0;
    txd_s      = 1'b1;
    busy_s     = 1'b0;
    accept_s   = bus.ld & (state_r == ST_IDLE);
    // The divider is being zeroed this cycle, so its tick is stale.
    tick_en_s  = bus.tick16 & ~div_clr_r & (state_r != ST_IDLE);
    cell_end_s = tick_en_s & (tick_cnt_r == TICK_LAST);

    if (cell_end_s) begin
      tick_cnt_s = '0;
    end else if (tick_en_s) begin
      tick_cnt_s = tick_cnt_r + TW'(1);
    end else begin
      tick_cnt_s = tick_cnt_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (bus.ld) begin
          state_s    = ST_START;
          shreg_s    = bus.data;
          tick_cnt_s = '0;
          bit_cnt_s  = 4'd0;
          div_clr_s  = 1'b1;
        end else begin
          state_s    = ST_IDLE;
        end
      end
      ST_START: begin
        if (cell_end_s) begin
          state_s   = ST_DATA;
          bit_cnt_s = 4'd0;
        end else begin
          state_s   = ST_START;
        end
      end
      ST_DATA: begin
        if (cell_end_s) begin
          shreg_s = {1'b0, shreg_r[DATA_BITS-1:1]};
          if (bit_cnt_r == DATA_LAST) begin
            state_s   = ST_STOP;
            bit_cnt_s = 4'd0;
          end else begin
            bit_cnt_s = bit_cnt_r + 4'd1;
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_STOP: begin
        if (cell_end_s) begin
          if (bit_cnt_r == STOP_LAST) begin
            state_s   = ST_IDLE;
            bit_cnt_s = 4'd0;
            done_s    = 1'b1;
          end else begin
            bit_cnt_s = bit_cnt_r + 4'd1;
          end
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s    = ST_IDLE;
        tick_cnt_s = '0;
        bit_cnt_s  = 4'd0;
      end
    endcase

    // Completion beats a same-cycle clear; an accepted load starts a fresh flag.
    if (done_s) begin
      flag_s = 1'b1;
    end else if (accept_s || bus.clr_flag) begin
      flag_s = 1'b0;
    end else begin
      flag_s = flag_r;
    end

    if (bus.ld && (state_r != ST_IDLE)) begin
      overrun_s = 1'b1;
    end else if (bus.clr_flag) begin
      overrun_s = 1'b0;
    end else begin
      overrun_s = overrun_r;
    end

    case (state_s)
      ST_IDLE:  txd_s = 1'b1;
      ST_START: txd_s = 1'b0;
      ST_DATA:  txd_s = shreg_s[0];
      ST_STOP:  txd_s = 1'b1;
      default:  txd_s = 1'b1;
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and registered-output update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      tick_cnt_r <= '0;
      bit_cnt_r  <= 4'd0;
      shreg_r    <= '0;
      txd_r      <= 1'b1;
      busy_r     <= 1'b0;
      flag_r     <= 1'b0;
      overrun_r  <= 1'b0;
      div_clr_r  <= 1'b0;
    end else begin
      state_r    <= state_s;
      tick_cnt_r <= tick_cnt_s;
      bit_cnt_r  <= bit_cnt_s;
      shreg_r    <= shreg_s;
      txd_r      <= txd_s;
      busy_r     <= busy_s;
      flag_r     <= flag_s;
      overrun_r  <= overrun_s;
      div_clr_r  <= div_clr_s;
    end
  end

  assign bus.txd     = txd_r;
  assign bus.busy    = busy_r;
  assign bus.flag    = flag_r;
  assign bus.overrun = overrun_r;
  assign bus.div_clr = div_clr_r;

endmodule

// File: tb/tb_tty_tx_sequencer.sv
// Bench for tty_tx_sequencer: an 8N2 and a 7N1 instance share one stimulus
// stream and are compared every cycle against a frame-level reference model.
module tb_tty_tx_sequencer;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  tty_tx_sequencer_if #(.DATA_BITS(8)) bus_a ();
  tty_tx_sequencer_if #(.DATA_BITS(7)) bus_b ();

  tty_tx_sequencer #(.DATA_BITS(8), .STOP_BITS(2), .TICKS_PER_BIT(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  tty_tx_sequencer #(.DATA_BITS(7), .STOP_BITS(1), .TICKS_PER_BIT(16)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  int total = 0;
  int bad   = 0;

  // Frame-level model: active flag, accepted tick count and the whole frame as bits.
  typedef struct {
    bit        act;
    int        k;
    bit [15:0] fr;
    bit        flag;
    bit        ovr;
    bit        dclr;
  } mdl_t;

  mdl_t ma;
  mdl_t mb;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic mdl_t mclr();
    mdl_t m;
    m.act  = 1'b0;
    m.k    = 0;
    m.fr   = 16'hFFFF;
    m.flag = 1'b0;
    m.ovr  = 1'b0;
    m.dclr = 1'b0;
    return m;
  endfunction

  function automatic mdl_t mstep(input mdl_t m, input int nd, input int ns, input int nt,
                                 input bit rst, input bit ld, input logic [7:0] d,
                                 input bit clr, input bit tk);
    mdl_t n;
    n = m;
    n.dclr = 1'b0;
    if (rst) return mclr();
    if (m.act) begin
      if (tk && !m.dclr) begin
        n.k = m.k + 1;
        if (n.k == (1 + nd + ns) * nt) begin
          n.act = 1'b0;
          n.k   = 0;
        end
      end
      if (ld) n.ovr = 1'b1;
      else if (clr) n.ovr = 1'b0;
    end else begin
      if (ld) begin
        n.act   = 1'b1;
        n.k     = 0;
        n.dclr  = 1'b1;
        n.fr    = 16'hFFFF;
        n.fr[0] = 1'b0;
        for (int i = 0; i < nd; i++) n.fr[1+i] = d[i];
      end
      if (clr) n.ovr = 1'b0;
    end
    if (m.act && !n.act) n.flag = 1'b1;
    else if (ld && !m.act) n.flag = 1'b0;
    else if (clr) n.flag = 1'b0;
    return n;
  endfunction

  // Expected {txd, busy, flag, overrun, div_clr}.
  function automatic int mout(input mdl_t m, input int nt);
    bit t;
    t = m.act ? m.fr[m.k / nt] : 1'b1;
    return int'({t, m.act, m.flag, m.ovr, m.dclr});
  endfunction

  function automatic logic [10:0] exp_cells(input logic [7:0] d);
    return {2'b11, d, 1'b0};
  endfunction

  task automatic cycle(input bit rst, input bit ld, input logic [7:0] d, input bit clr, input bit tk);
    @(negedge clk);
    reset          = rst;
    bus_a.ld       = ld;
    bus_a.data     = d;
    bus_a.clr_flag = clr;
    bus_a.tick16   = tk;
    bus_b.ld       = ld;
    bus_b.data     = d[6:0];
    bus_b.clr_flag = clr;
    bus_b.tick16   = tk;
    @(posedge clk);
    ma = mstep(ma, 8, 2, 16, rst, ld, d, clr, tk);
    mb = mstep(mb, 7, 1, 16, rst, ld, d, clr, tk);
    #1;
    check("A.out", int'({bus_a.txd, bus_a.busy, bus_a.flag, bus_a.overrun, bus_a.div_clr}), mout(ma, 16));
    check("B.out", int'({bus_b.txd, bus_b.busy, bus_b.flag, bus_b.overrun, bus_b.div_clr}), mout(mb, 16));
  endtask

  // Load d, then issue ntick ticks spaced gap clks apart; samples A's txd mid-cell.
  task automatic send_frame(input logic [7:0] d, input int gap, input int ntick, input int ld_at,
                            input int clr_at, input int rst_at, input bit chk,
                            output logic [10:0] cells);
    cells = '0;
    cycle(1'b0, 1'b1, d, 1'b0, 1'b0);
    check("A.div_clr_hi", int'(bus_a.div_clr), 1);
    for (int t = 1; t <= ntick; t++) begin
      for (int g = 0; g < gap - 1; g++) begin
        cycle(1'b0, (t == ld_at) && (g == 0), 8'h00, 1'b0, 1'b0);
        if (t == 1 && g == 0) check("A.div_clr_lo", int'(bus_a.div_clr), 0);
      end
      cycle(1'b0, 1'b0, 8'h00, t == clr_at, 1'b1);
      if ((t % 16) == 8 && (t / 16) < 11) cells[t/16] = bus_a.txd;
      if (chk && t == 143) check("B.flag@143", int'(bus_b.flag), 0);
      if (chk && t == 144) check("B.flag@144", int'({bus_b.flag, bus_b.busy}), 2);
      if (chk && t == 175) check("A.flag@175", int'({bus_a.flag, bus_a.busy}), 1);
      if (chk && t == 176) check("A.flag@176", int'({bus_a.flag, bus_a.busy}), 2);
      if (t == rst_at) begin
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        return;
      end
    end
  endtask

  logic [10:0] cells;

  initial begin
    reset          = 1'b1;
    bus_a.ld       = 1'b0;
    bus_a.data     = 8'h00;
    bus_a.clr_flag = 1'b0;
    bus_a.tick16   = 1'b0;
    bus_b.ld       = 1'b0;
    bus_b.data     = 7'h00;
    bus_b.clr_flag = 1'b0;
    bus_b.tick16   = 1'b0;
    ma = mclr();
    mb = mclr();

    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("rst.out", int'({bus_a.txd, bus_a.busy, bus_a.flag, bus_a.overrun, bus_a.div_clr}), 16);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("idle.tick", int'({bus_a.txd, bus_a.busy}), 2);

    // 0x41 with a tick every 10 clks.
    send_frame(8'h41, 10, 176, -1, -1, -1, 1'b1, cells);
    check("A.cells41", int'(cells), int'(11'b110_1000_0010));
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("A.clr", int'(bus_a.flag), 0);

    // Overrun: a second load at tick 50 must not disturb the frame.
    send_frame(8'hA5, 4, 176, 50, -1, -1, 1'b1, cells);
    check("A.cellsA5", int'(cells), int'(exp_cells(8'hA5)));
    check("A.ovr", int'(bus_a.overrun), 1);
    check("B.ovr", int'(bus_b.overrun), 1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("A.ovr_clr", int'({bus_a.flag, bus_a.overrun}), 0);

    // clr_flag on the completing tick: set wins, a later clear works.
    send_frame(8'h3C, 4, 176, -1, 176, -1, 1'b1, cells);
    check("A.setwins", int'(bus_a.flag), 1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    check("A.clr_late", int'(bus_a.flag), 0);

    // Reset mid-frame, then a clean frame.
    send_frame(8'hC3, 4, 176, -1, -1, 80, 1'b0, cells);
    check("A.rst_mid", int'({bus_a.txd, bus_a.busy, bus_a.flag}), 4);
    check("B.rst_mid", int'({bus_b.txd, bus_b.busy, bus_b.flag}), 4);
    send_frame(8'h55, 3, 176, -1, -1, -1, 1'b1, cells);
    check("A.cells55", int'(cells), int'(exp_cells(8'h55)));

    // Tick coinciding with div_clr is ignored.
    cycle(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int t = 1; t <= 15; t++) begin
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    end
    check("A.start_hold", int'(bus_a.txd), 0);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("A.start_end", int'(bus_a.txd), 1);
    for (int t = 17; t <= 176; t++) cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    check("A.ff_done", int'({bus_a.flag, bus_a.busy}), 2);

    // Random traffic against the model.
    for (int i = 0; i < 6000; i++) begin
      cycle($urandom_range(0, 2999) == 0, $urandom_range(0, 59) == 0, 8'($urandom),
            $urandom_range(0, 79) == 0, $urandom_range(0, 2) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
